// File: rtl/p_beid_interconnect_ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HRESP encodings, the
// default-slave state enum and a constant-evaluable clog2 helper.
package p_beid_interconnect_ahb_mtx_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } dft_state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/p_beid_interconnect_ahb_mtx_decoder_gen_if.sv
// Input-stage <-> decoder <-> output-stage signal bundle.
// slave  : decoder view (address/data-phase inputs in, selects/muxed response out)
// master : environment view (input stage and output stages)
interface p_beid_interconnect_ahb_mtx_decoder_gen_if #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DW        = 32,
  parameter int unsigned RUW       = 4
);
  logic                     HREADYS;
  logic                     sel_dec;
  logic [21:0]              decode_addr_dec;
  logic [1:0]               trans_dec;
  logic [NUM_PORTS-1:0]     active_dec_i;
  logic [NUM_PORTS-1:0]     readyout_dec_i;
  logic [2*NUM_PORTS-1:0]   resp_dec_i;
  logic [DW*NUM_PORTS-1:0]  rdata_dec_i;
  logic [RUW*NUM_PORTS-1:0] ruser_dec_i;
  logic [NUM_PORTS-1:0]     sel_dec_o;
  logic                     active_dec;
  logic                     HREADYOUTS;
  logic [1:0]               HRESPS;
  logic [DW-1:0]            HRDATAS;
  logic [RUW-1:0]           HRUSERS;

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
    input  active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
    output sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
    output active_dec_i, readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i,
    input  sel_dec_o, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );
endinterface

// File: rtl/p_beid_interconnect_ahb_mtx_dft_slv_gen.sv
// Default slave: two-cycle AHB ERROR response for accepted NONSEQ/SEQ
// transfers to unmapped space, zero-wait OKAY otherwise.
// Ports: HCLK/HRESETn; sel_i (default slave addressed), hready_i (HREADYS),
// xfer_i (HTRANS is NONSEQ/SEQ); hreadyout_o, hresp_o, err_o (first ERROR cycle).
module p_beid_interconnect_ahb_mtx_dft_slv_gen (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel_i,
  input  logic       hready_i,
  input  logic       xfer_i,
  output logic       hreadyout_o,
  output logic [1:0] hresp_o,
  output logic       err_o
);
  import p_beid_interconnect_ahb_mtx_pkg::*;

  dft_state_e state_q, state_d;
  logic       accept;

  assign accept = sel_i & hready_i & xfer_i;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  // Next state and response
  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = RESP_OKAY;
    err_o       = 1'b0;
    unique case (state_q)
      DS_IDLE: if (accept) state_d = DS_ERR1;
      DS_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = RESP_ERROR;
        err_o       = 1'b1;
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = RESP_ERROR;
        state_d = accept ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/p_beid_interconnect_ahb_mtx_decoder_gen.sv
// AHB bus-matrix input-stage decoder: prioritised region decode with remap
// gating, one-hot HSEL to the output stages, registered data-phase port and
// response mux, plus an integrated default slave for unmapped addresses.
// Ports: HCLK/HRESETn; remapping_dec (remap controls); bus_if (slave modport:
// input-stage address/data phase and per-port responses); dft_err_o (pulse on
// the first ERROR cycle of the default slave).
module p_beid_interconnect_ahb_mtx_decoder_gen #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned NUM_REMAP   = 1,
  parameter int unsigned DW          = 32,
  parameter int unsigned RUW         = 4,
  parameter logic [NUM_REGIONS*22-1:0] REGION_BASE  = {NUM_REGIONS{22'h0}},
  parameter logic [NUM_REGIONS*22-1:0] REGION_LIMIT = {NUM_REGIONS{22'h0}},
  parameter logic [NUM_REGIONS*4-1:0]  REGION_PORT  = {NUM_REGIONS{4'h0}},
  parameter logic [NUM_REGIONS*3-1:0]  REGION_REMAP = {NUM_REGIONS{3'h0}}
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_REMAP-1:0] remapping_dec,
  p_beid_interconnect_ahb_mtx_decoder_gen_if.slave bus_if,
  output logic                 dft_err_o
);
  import p_beid_interconnect_ahb_mtx_pkg::*;

  localparam int unsigned PW  = clog2(NUM_PORTS + 1);
  localparam int unsigned DFT = NUM_PORTS;

  logic [PW-1:0]        hit_port, addr_port, data_port_q, data_port_d;
  logic [NUM_PORTS-1:0] sel_vec;
  logic                 act, dft_sel, xfer;
  logic                 dft_ready;
  logic [1:0]           dft_resp;

  // Flag table entries that point past the last output stage; they decode to DFT.
  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_port_chk
    if (32'(REGION_PORT[r*4 +: 4]) >= NUM_PORTS) begin : g_bad
      $warning("region %0d targets port beyond NUM_PORTS; decoded as default slave", r);
    end
  end

  function automatic logic remap_ok(input logic [2:0] code, input logic [NUM_REMAP-1:0] rm);
    remap_ok = (code == 3'd0);
    for (int k = 0; k < int'(NUM_REMAP); k++) begin
      if ((code == 3'(k + 1)) && rm[k]) remap_ok = 1'b1;
    end
  endfunction

  // Region decode; scanning downwards lets the lowest-index hit win.
  always_comb begin
    hit_port = PW'(DFT);
    for (int r = int'(NUM_REGIONS) - 1; r >= 0; r--) begin
      if ((bus_if.decode_addr_dec >= REGION_BASE[r*22 +: 22]) &&
          (bus_if.decode_addr_dec <= REGION_LIMIT[r*22 +: 22]) &&
          remap_ok(REGION_REMAP[r*3 +: 3], remapping_dec)) begin
        hit_port = (32'(REGION_PORT[r*4 +: 4]) < NUM_PORTS) ? PW'(REGION_PORT[r*4 +: 4])
                                                             : PW'(DFT);
      end
    end
  end

  // IDLE cycles keep the current data-phase port so selects do not toggle.
  assign addr_port = (bus_if.trans_dec == TRANS_IDLE) ? data_port_q : hit_port;
  assign xfer      = (bus_if.trans_dec & TRANS_NONSEQ) != 2'b00;
  assign dft_sel   = bus_if.sel_dec && (addr_port == PW'(DFT));

  // One-hot selects and addressed-port active
  always_comb begin
    sel_vec = '0;
    act     = 1'b1;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      sel_vec[p] = bus_if.sel_dec && (addr_port == PW'(p));
      if (addr_port == PW'(p)) act = bus_if.active_dec_i[p];
    end
  end

  assign bus_if.sel_dec_o  = sel_vec;
  assign bus_if.active_dec = act;

  // Data-phase port advances only when the input stage completes a cycle.
  assign data_port_d = bus_if.HREADYS ? addr_port : data_port_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) data_port_q <= '0;
    else          data_port_q <= data_port_d;
  end

  // Data-phase response mux; the default slave returns zero data/user.
  always_comb begin
    bus_if.HREADYOUTS = dft_ready;
    bus_if.HRESPS     = dft_resp;
    bus_if.HRDATAS    = '0;
    bus_if.HRUSERS    = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (data_port_q == PW'(p)) begin
        bus_if.HREADYOUTS = bus_if.readyout_dec_i[p];
        bus_if.HRESPS     = bus_if.resp_dec_i[2*p +: 2];
        bus_if.HRDATAS    = bus_if.rdata_dec_i[DW*p +: DW];
        bus_if.HRUSERS    = bus_if.ruser_dec_i[RUW*p +: RUW];
      end
    end
  end

  p_beid_interconnect_ahb_mtx_dft_slv_gen u_dft_slv (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .sel_i       (dft_sel),
    .hready_i    (bus_if.HREADYS),
    .xfer_i      (xfer),
    .hreadyout_o (dft_ready),
    .hresp_o     (dft_resp),
    .err_o       (dft_err_o)
  );

endmodule
